// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_det_pkg;

    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 16;

    typedef enum logic [1:0] {
        ST_FILL   = 2'b00,
        ST_SEARCH = 2'b01,
        ST_HIT    = 2'b10
    } seq_state_e;

    // Width of a counter that can hold 0..pat_w inclusive.
    function automatic int unsigned fill_width(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// Bit-history shift register with a saturating count of accepted bits.
module seq_hist_shreg
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W  = 4,
    parameter int unsigned FILL_W = fill_width(PAT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              din,
    output logic [PAT_W-1:0]  hist,
    output logic [FILL_W-1:0] fill
);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = {hist_q[PAT_W-2:0], din};
            if (fill_q != FILL_W'(PAT_W)) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign fill = fill_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Run-time loadable serial pattern detector with registered match pulse.
// Optional saturating hit counter enabled by defining SEQDET_COUNT_EN.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1001),
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_en,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned FILL_W  = fill_width(PAT_W);
    localparam int unsigned FILL_NW = FILL_W + 1;

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_pat_w_check
        $error("seq_pattern_detector: PAT_W out of range");
    end

    seq_state_e        state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              match_q, match_d;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [FILL_NW-1:0] fill_nx;
    logic              fill_ok_now;
    logic              fill_ok_nx;
    logic              hit_c;
    logic              shreg_clr_c;
    logic              shreg_shift_c;

    // Pattern completes when the incoming bit plus held history equals pat.
    always_comb begin
        fill_nx     = {1'b0, fill} + FILL_NW'(din_valid);
        fill_ok_now = ({1'b0, fill} >= FILL_NW'(PAT_W - 1));
        fill_ok_nx  = (fill_nx >= FILL_NW'(PAT_W - 1));
        hit_c       = din_valid && !pat_load && fill_ok_now &&
                      ({hist[PAT_W-2:0], din} == pat_q);
    end

    assign shreg_clr_c   = pat_load || (hit_c && !overlap_en);
    assign shreg_shift_c = din_valid && !pat_load;

    seq_hist_shreg #(
        .PAT_W  (PAT_W),
        .FILL_W (FILL_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clr      (shreg_clr_c),
        .shift_en (shreg_shift_c),
        .din      (din),
        .hist     (hist),
        .fill     (fill)
    );

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        match_d = 1'b0;
        if (pat_load) begin
            pat_d   = pat_in;
            state_d = ST_FILL;
        end else if (hit_c) begin
            state_d = ST_HIT;
            match_d = 1'b1;
        end else begin
            case (state_q)
                ST_FILL:   if (din_valid && fill_ok_nx) state_d = ST_SEARCH;
                ST_SEARCH: state_d = ST_SEARCH;
                ST_HIT:    state_d = fill_ok_nx ? ST_SEARCH : ST_FILL;
                default:   state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            pat_q   <= PAT_RST;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts cycles with match high; saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (pat_load) begin
            cnt_d = '0;
        end else if (match_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: directed table plus random run.
module tb_seq_pattern_detector;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din_valid = 1'b0;
    logic             din = 1'b0;
    logic             pat_load = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic             overlap_en = 1'b1;
    logic             match;
    logic [CNT_W-1:0] match_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_pattern_detector #(
        .PAT_W   (PAT_W),
        .PAT_RST (4'b1001),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .overlap_en (overlap_en),
        .match      (match),
        .match_cnt  (match_cnt)
    );

    typedef struct {
        logic             r;
        logic             v;
        logic             d;
        logic             ld;
        logic [PAT_W-1:0] pi;
        logic             ovl;
        logic             em;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the bits accepted since the last clear, newest last.
    bit               mq[$];
    logic [PAT_W-1:0] mpat = 4'b1001;
    int               mcnt = 0;
    logic             mprev = 1'b0;

    function automatic logic [PAT_W-1:0] model_window();
        logic [PAT_W-1:0] p = '0;
        for (int i = 0; i < mq.size(); i++) p = {p[PAT_W-2:0], mq[i]};
        return p;
    endfunction

    task automatic add(input logic r, input logic v, input logic d, input logic ld,
                       input logic [PAT_W-1:0] pi, input logic ovl, input logic em);
        vec_t e;
        e.r = r; e.v = v; e.d = d; e.ld = ld; e.pi = pi; e.ovl = ovl; e.em = em;
        vecs.push_back(e);
    endtask

    // bits/hits are listed first-bit-first from bit n-1 down to bit 0.
    task automatic add_stream(input logic [15:0] bits, input int n, input logic ovl,
                              input logic [15:0] hits);
        for (int i = n - 1; i >= 0; i--) add(1'b0, 1'b1, bits[i], 1'b0, '0, ovl, hits[i]);
    endtask

    task automatic cycle(input logic r, input logic v, input logic d, input logic ld,
                         input logic [PAT_W-1:0] pi, input logic ovl,
                         input logic use_tab, input logic tab_em, input string name);
        logic em;
        int   exp_cnt;
        em = 1'b0;
        if (r) begin
            mq.delete();
            mpat = 4'b1001;
        end else if (ld) begin
            mq.delete();
            mpat = pi;
        end else if (v) begin
            mq.push_back(d);
            if (mq.size() > PAT_W) void'(mq.pop_front());
            if (mq.size() == PAT_W && model_window() == mpat) begin
                em = 1'b1;
                if (!ovl) mq.delete();
            end
        end
        if (use_tab) em = tab_em;
        if (r || ld) mcnt = 0;
        else if (mprev && mcnt < CNT_MAX) mcnt++;
        mprev = em;

        rst = r; din_valid = v; din = d; pat_load = ld; pat_in = pi; overlap_en = ovl;
        @(posedge clk);
        #1;
`ifdef SEQDET_COUNT_EN
        exp_cnt = mcnt;
`else
        exp_cnt = 0;
`endif
        checks++;
        if (match !== em) begin
            errors++;
            $display("FAIL %s match: got %b expected %b", name, match, em);
        end
        checks++;
        if (int'(match_cnt) != exp_cnt || $isunknown(match_cnt)) begin
            errors++;
            $display("FAIL %s match_cnt: got %0d expected %0d", name, match_cnt, exp_cnt);
        end
    endtask

    initial begin
        // reset + default pattern
        add(1, 0, 0, 0, '0, 1, 0);
        add_stream(16'b1001, 4, 1'b1, 16'b0001);
        add(0, 0, 1, 0, '0, 1, 0);
        // overlapping vs non-overlapping
        add(1, 0, 0, 0, '0, 1, 0);
        add_stream(16'b1001001, 7, 1'b1, 16'b0001001);
        add(0, 0, 0, 0, '0, 1, 0);
        add(1, 0, 0, 0, '0, 0, 0);
        add_stream(16'b1001001, 7, 1'b0, 16'b0001000);
        add(0, 0, 0, 0, '0, 0, 0);
        // back-to-back hits with 1111
        add(0, 0, 0, 1, 4'hF, 1, 0);
        add_stream(16'b11111, 5, 1'b1, 16'b00011);
        add(0, 0, 0, 0, '0, 1, 0);
        add(0, 0, 0, 1, 4'hF, 0, 0);
        add_stream(16'b11111111, 8, 1'b0, 16'b00010001);
        add(0, 0, 0, 0, '0, 0, 0);
        // din_valid gaps with toggling din
        add(1, 0, 0, 0, '0, 1, 0);
        add(0, 1, 1, 0, '0, 1, 0);
        add(0, 0, 0, 0, '0, 1, 0);
        add(0, 1, 0, 0, '0, 1, 0);
        add(0, 0, 1, 0, '0, 1, 0);
        add(0, 0, 0, 0, '0, 1, 0);
        add(0, 1, 0, 0, '0, 1, 0);
        add(0, 0, 1, 0, '0, 1, 0);
        add(0, 0, 0, 0, '0, 1, 0);
        add(0, 0, 1, 0, '0, 1, 0);
        add(0, 1, 1, 0, '0, 1, 1);
        add(0, 0, 0, 0, '0, 1, 0);
        // pat_load mid-stream, concurrent din dropped
        add(1, 0, 0, 0, '0, 1, 0);
        add_stream(16'b1001, 4, 1'b1, 16'b0001);
        add_stream(16'b100, 3, 1'b1, 16'b000);
        add(0, 1, 1, 1, 4'h0, 1, 0);
        add_stream(16'b0000, 4, 1'b1, 16'b0001);
        add(0, 0, 0, 0, '0, 1, 0);
        // rst during the match cycle
        add(1, 0, 0, 0, '0, 1, 0);
        add_stream(16'b1001, 4, 1'b1, 16'b0001);
        add(1, 0, 0, 0, '0, 1, 0);
        add_stream(16'b1001, 4, 1'b1, 16'b0001);
        add(0, 0, 0, 0, '0, 1, 0);
        // five overlapping hits, counter saturation
        add(1, 0, 0, 0, '0, 1, 0);
        add_stream(16'b1001001001001001, 16, 1'b1, 16'b0001001001001001);
        add(0, 0, 0, 0, '0, 1, 0);
        add(0, 0, 0, 0, '0, 1, 0);

        foreach (vecs[i])
            cycle(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].ld, vecs[i].pi,
                  vecs[i].ovl, 1'b1, vecs[i].em, $sformatf("vec%0d", i));

        // randomized run against the reference model
        cycle(1, 0, 0, 0, '0, 1, 1'b0, 1'b0, "rand_rst");
        for (int n = 0; n < 3000; n++) begin
            logic             r, v, d, ld, ovl;
            logic [PAT_W-1:0] pi;
            r   = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 39) == 0);
            v   = ($urandom_range(0, 9) < 7);
            d   = 1'($urandom);
            ovl = 1'($urandom);
            pi  = PAT_W'($urandom);
            cycle(r, v, d, ld, pi, ovl, 1'b0, 1'b0, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
